// File: rtl/spill_fill_manager.sv
// Spill/fill manager: parks a FIFO's tail words in a LIFO backing store and
// returns them in reverse order, one bounded burst per grant.
module spill_fill_manager #(
  parameter int DATA_WIDTH  = 32,
  parameter int STORE_DEPTH = 4096,
  parameter int BURST_LEN   = 64,
  parameter int STALL_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spill_req,
  output logic                         spill_grant,
  input  logic [DATA_WIDTH-1:0]        spill_data,
  input  logic                         spill_data_valid,
  output logic                         spill_data_ready,
  input  logic                         fill_req,
  output logic                         fill_grant,
  output logic [DATA_WIDTH-1:0]        fill_data,
  output logic                         fill_data_valid,
  input  logic                         fill_data_ready,
  output logic [$clog2(STORE_DEPTH):0] store_count,
  output logic                         store_empty,
  output logic                         store_full,
  output logic                         busy
);
  localparam int AW = $clog2(STORE_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(STORE_DEPTH);
  localparam logic [BW-1:0] BURST_C = BW'(BURST_LEN);
  localparam logic [SW-1:0] STALL_C = SW'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   sp_q, sp_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            armed_q;
  logic            spill_grant_q, fill_grant_q;
  logic            spill_xfer, fill_xfer;
  logic [AW-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0] mem_q [STORE_DEPTH];

  assign store_count = sp_q;
  assign store_empty = (sp_q == '0);
  assign store_full  = (sp_q == DEPTH_C);
  assign busy        = (state_q != IDLE);
  assign spill_grant = spill_grant_q;
  assign fill_grant  = fill_grant_q;
  assign spill_xfer  = spill_data_valid && spill_data_ready;
  assign fill_xfer   = fill_data_valid && fill_data_ready;
  assign rd_idx      = AW'(sp_q - CW'(1));
  assign fill_data   = mem_q[rd_idx];

  // armed_q holds off the first grant until one edge has passed after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sp_q          <= '0;
      burst_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      armed_q       <= 1'b0;
      spill_grant_q <= 1'b0;
      fill_grant_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      burst_cnt_q   <= burst_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      armed_q       <= 1'b1;
      spill_grant_q <= (state_d == SPILL);
      fill_grant_q  <= (state_d == FILL);
    end
  end

  always_ff @(posedge clk) begin
    if (spill_xfer) mem_q[sp_q[AW-1:0]] <= spill_data;
  end

  // Counters sit at zero outside a burst, so they start cleared on entry
  always_comb begin
    sp_d        = sp_q;
    burst_cnt_d = '0;
    stall_cnt_d = '0;
    if (state_q == SPILL || state_q == FILL) begin
      burst_cnt_d = burst_cnt_q;
      stall_cnt_d = stall_cnt_q + SW'(1);
      if (spill_xfer) begin
        sp_d        = sp_q + CW'(1);
        burst_cnt_d = burst_cnt_q + BW'(1);
        stall_cnt_d = '0;
      end else if (fill_xfer) begin
        sp_d        = sp_q - CW'(1);
        burst_cnt_d = burst_cnt_q + BW'(1);
        stall_cnt_d = '0;
      end
    end
  end

  // Burst end is judged on post-edge values so the last transfer and the
  // move to RELEASE share one edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          if (spill_req && !store_full)      state_d = SPILL;
          else if (fill_req && !store_empty) state_d = FILL;
        end
      end
      SPILL: begin
        if (burst_cnt_d == BURST_C || sp_d == DEPTH_C || stall_cnt_d == STALL_C)
          state_d = RELEASE;
      end
      FILL: begin
        if (burst_cnt_d == BURST_C || sp_d == '0 || stall_cnt_d == STALL_C)
          state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spill_data_ready = 1'b0;
    fill_data_valid  = 1'b0;
    case (state_q)
      SPILL:   spill_data_ready = !store_full && (burst_cnt_q < BURST_C);
      FILL:    fill_data_valid  = !store_empty && (burst_cnt_q < BURST_C);
      default: ;
    endcase
  end

endmodule
